// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state encoding for the Game Boy core.
// Also holds the echo-RAM aliasing rule used to fold source pages.
package gb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        XFER = 2'd2
    } dma_state_e;

    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam logic [15:0] DMA_REG     = 16'hFF46;
    localparam logic [7:0]  ECHO_OFFSET = 8'h20;

    // Pages E0..FF mirror C0..DF, so the DMA reads the real work RAM instead.
    function automatic logic [7:0] echoAlias(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - ECHO_OFFSET) : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the OAM DMA controller (master) and the CPU register port,
// the source memory map and OAM port A (slave side).
interface oam_dma_ctrl_if;

    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] src_addr;
    logic        src_rd_en;
    logic [7:0]  src_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        busy;
    logic        cpu_block;

    modport master (
        input  reg_we, reg_wdata, src_rdata,
        output reg_rdata, src_addr, src_rd_en, oam_addr, oam_wdata, oam_we,
               busy, cpu_block
    );

    modport slave (
        output reg_we, reg_wdata, src_rdata,
        input  reg_rdata, src_addr, src_rd_en, oam_addr, oam_wdata, oam_we,
               busy, cpu_block
    );

endinterface

// File: rtl/dma_pacer.sv
// Per-byte pacing counter for the OAM DMA: splits each M-cycle into a read slot,
// a write slot and an end-of-byte strobe.
module dma_pacer #(
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic rd_slot_o,
    output logic wr_slot_o,
    output logic byte_done_o
);

    localparam int             PW   = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0]  LAST = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0]  ONE  = PW'(1);

    logic [PW-1:0] pace_q;
    logic [PW-1:0] pace_d;

    always_comb begin
        pace_d = pace_q;
        if (clr_i || !en_i) begin
            pace_d = '0;
        end else if (pace_q == LAST) begin
            pace_d = '0;
        end else begin
            pace_d = pace_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pace_q <= '0;
        end else begin
            pace_q <= pace_d;
        end
    end

    assign rd_slot_o   = en_i && (pace_q == '0);
    assign wr_slot_o   = en_i && (pace_q == ONE);
    assign byte_done_o = en_i && (pace_q == LAST);

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to 0xFF46 copies XFER_LEN bytes from page<<8 into OAM.
// Define OAM_DMA_RESTART_EN to let a register write during a transfer restart it.
module oam_dma_ctrl
    import gb_mem_pkg::*;
#(
    parameter int XFER_LEN        = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    oam_dma_ctrl_if.master bus
);

    localparam dma_state_e  TRIG_STATE = (START_DELAY == 0) ? XFER : ARM;
    localparam logic [7:0]  LAST_IDX   = 8'(XFER_LEN - 1);
    localparam logic [15:0] LAST_DELAY = 16'(START_DELAY - 1);

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] delay_q, delay_d;

    logic       rdSlot;
    logic       wrSlot;
    logic       byteDone;
    logic       restart;
    logic       pacerClr;
    logic       busy;
    logic [7:0] effPage;

`ifdef OAM_DMA_RESTART_EN
    assign restart = bus.reg_we && (state_q != IDLE);
`else
    assign restart = 1'b0;
`endif

    // The pacer is held at zero whenever the next cycle is not a continuing XFER,
    // which also drops the aborted byte's pending write slot on a restart.
    assign pacerClr = (state_d != XFER) || restart;

    dma_pacer #(
        .CYCLES_PER_BYTE(CYCLES_PER_BYTE)
    ) pacer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == XFER),
        .clr_i       (pacerClr),
        .rd_slot_o   (rdSlot),
        .wr_slot_o   (wrSlot),
        .byte_done_o (byteDone)
    );

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        delay_d = delay_q;
        unique case (state_q)
            IDLE: begin
                if (bus.reg_we) begin
                    page_d  = bus.reg_wdata;
                    idx_d   = '0;
                    delay_d = '0;
                    state_d = TRIG_STATE;
                end
            end
            ARM: begin
                if (delay_q == LAST_DELAY) begin
                    idx_d   = '0;
                    delay_d = '0;
                    state_d = XFER;
                end else begin
                    delay_d = delay_q + 16'd1;
                end
            end
            XFER: begin
                // Leave right after the last write so idx never steps past LAST_IDX.
                if (wrSlot && (idx_q == LAST_IDX)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (byteDone) begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (restart) begin
            page_d  = bus.reg_wdata;
            idx_d   = '0;
            delay_d = '0;
            state_d = TRIG_STATE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            delay_q <= delay_d;
        end
    end

    assign effPage = echoAlias(page_q);
    assign busy    = (state_q != IDLE);

    assign bus.reg_rdata = page_q;
    assign bus.src_rd_en = rdSlot;
    assign bus.src_addr  = rdSlot ? {effPage, idx_q} : 16'h0000;
    assign bus.oam_we    = wrSlot;
    assign bus.oam_addr  = wrSlot ? idx_q : 8'h00;
    assign bus.oam_wdata = wrSlot ? bus.src_rdata : 8'h00;
    assign bus.busy      = busy;
    assign bus.cpu_block = busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: default-parameter instance plus a small
// fast instance, with a 1-cycle BRAM source model on each.
module tb_oam_dma_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    oam_dma_ctrl_if mainIf ();
    oam_dma_ctrl_if smallIf ();

    oam_dma_ctrl #(
        .XFER_LEN(160), .CYCLES_PER_BYTE(4), .START_DELAY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(mainIf.master)
    );

    oam_dma_ctrl #(
        .XFER_LEN(4), .CYCLES_PER_BYTE(2), .START_DELAY(0)
    ) dutSmall (
        .clk(clk), .rst_n(rst_n), .bus(smallIf.master)
    );

    int checkCount = 0;
    int passCount  = 0;
    int invViolations = 0;

    // Source memory: data = low address byte XOR a per-instance key, one cycle after the strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            mainIf.src_rdata  <= 8'h00;
            smallIf.src_rdata <= 8'h00;
        end else begin
            if (mainIf.src_rd_en)  mainIf.src_rdata  <= mainIf.src_addr[7:0] ^ 8'h5A;
            if (smallIf.src_rd_en) smallIf.src_rdata <= smallIf.src_addr[7:0] ^ 8'hA5;
        end
    end

    always @(negedge clk) begin
        if (mainIf.src_rd_en && mainIf.oam_we)      invViolations++;
        if (mainIf.cpu_block !== mainIf.busy)       invViolations++;
        if (smallIf.src_rd_en && smallIf.oam_we)    invViolations++;
        if (smallIf.cpu_block !== smallIf.busy)     invViolations++;
    end

    task automatic startMain(input logic [7:0] page);
        @(negedge clk);
        mainIf.reg_we    = 1'b1;
        mainIf.reg_wdata = page;
    endtask

    task automatic test_reset();
        logic [43:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {mainIf.reg_rdata, mainIf.src_addr, mainIf.src_rd_en, mainIf.oam_addr,
                mainIf.oam_wdata, mainIf.oam_we, mainIf.busy, mainIf.cpu_block};
        checkCount++; if (outs !== 44'h0) $display("[TB] FAIL reset_outputs: got %h want 0", outs); else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
        checkCount++; if (mainIf.busy !== 1'b0) $display("[TB] FAIL reset_release_busy: got %b want 0", mainIf.busy); else passCount++;
    endtask

    task automatic test_transfer();
        int writes = 0, firstW = -1, lastW = -1, badSpacing = 0, badData = 0, lastBusy = -1;
        logic busyFirst = 1'b0;
        startMain(8'hC1);
        for (int c = 1; c <= 650; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mainIf.reg_we = 1'b0;
                busyFirst = mainIf.busy;
            end
            if (mainIf.busy) lastBusy = c;
            if (mainIf.oam_we) begin
                if (c != 6 + 4 * writes) badSpacing++;
                if (mainIf.oam_addr !== 8'(writes) || mainIf.oam_wdata !== (8'(writes) ^ 8'h5A)) badData++;
                if (firstW < 0) firstW = c;
                lastW = c;
                writes++;
            end
        end
        checkCount++; if (busyFirst !== 1'b1) $display("[TB] FAIL xfer_busy_cycle1: got %b want 1", busyFirst); else passCount++;
        checkCount++; if (writes != 160) $display("[TB] FAIL xfer_write_count: got %0d want 160", writes); else passCount++;
        checkCount++; if (firstW != 6) $display("[TB] FAIL xfer_first_write: got cycle %0d want 6", firstW); else passCount++;
        checkCount++; if (lastW != 642) $display("[TB] FAIL xfer_last_write: got cycle %0d want 642", lastW); else passCount++;
        checkCount++; if (badSpacing != 0) $display("[TB] FAIL xfer_spacing: got %0d misplaced want 0", badSpacing); else passCount++;
        checkCount++; if (badData != 0) $display("[TB] FAIL xfer_data: got %0d bad bytes want 0", badData); else passCount++;
        checkCount++; if (lastBusy != 642) $display("[TB] FAIL xfer_last_busy: got cycle %0d want 642", lastBusy); else passCount++;
        checkCount++; if (mainIf.reg_rdata !== 8'hC1) $display("[TB] FAIL xfer_rdata: got %h want c1", mainIf.reg_rdata); else passCount++;
    endtask

    task automatic test_echo();
        int reads = 0, badAddr = 0;
        logic [15:0] firstA = 16'h0, lastA = 16'h0;
        startMain(8'hE3);
        for (int c = 1; c <= 650; c++) begin
            @(negedge clk);
            if (c == 1) mainIf.reg_we = 1'b0;
            if (mainIf.src_rd_en) begin
                if (mainIf.src_addr !== {8'hC3, 8'(reads)}) badAddr++;
                if (reads == 0) firstA = mainIf.src_addr;
                lastA = mainIf.src_addr;
                reads++;
            end
        end
        checkCount++; if (firstA !== 16'hC300) $display("[TB] FAIL echo_first_addr: got %h want c300", firstA); else passCount++;
        checkCount++; if (lastA !== 16'hC39F) $display("[TB] FAIL echo_last_addr: got %h want c39f", lastA); else passCount++;
        checkCount++; if (reads != 160 || badAddr != 0) $display("[TB] FAIL echo_sequence: got %0d reads %0d bad want 160 0", reads, badAddr); else passCount++;
        checkCount++; if (mainIf.reg_rdata !== 8'hE3) $display("[TB] FAIL echo_rdata: got %h want e3", mainIf.reg_rdata); else passCount++;
    endtask

    task automatic test_restart();
`ifdef OAM_DMA_RESTART_EN
        localparam logic [7:0]  EXP_PAGE  = 8'hD0;
        localparam int          EXP_BUSY  = 842;
        localparam int          EXP_RDCYC = 205;
        localparam logic [15:0] EXP_RDADR = 16'hD000;
        localparam int          EXP_WR    = 209;
`else
        localparam logic [7:0]  EXP_PAGE  = 8'hC1;
        localparam int          EXP_BUSY  = 642;
        localparam int          EXP_RDCYC = 201;
        localparam logic [15:0] EXP_RDADR = 16'hC131;
        localparam int          EXP_WR    = 160;
`endif
        int writes = 0, lastBusy = -1, rdCyc = -1;
        logic [15:0] rdAdr = 16'h0;
        logic [7:0] rdataLate = 8'h00;
        startMain(8'hC1);
        for (int c = 1; c <= 860; c++) begin
            @(negedge clk);
            if (c == 1 || c == 201) mainIf.reg_we = 1'b0;
            if (mainIf.busy) lastBusy = c;
            if (mainIf.oam_we) writes++;
            if (mainIf.src_rd_en && c > 200 && rdCyc < 0) begin
                rdCyc = c;
                rdAdr = mainIf.src_addr;
            end
            if (c == 210) rdataLate = mainIf.reg_rdata;
            if (c == 200) begin
                mainIf.reg_we    = 1'b1;
                mainIf.reg_wdata = 8'hD0;
            end
        end
        checkCount++; if (rdataLate !== EXP_PAGE) $display("[TB] FAIL restart_rdata: got %h want %h", rdataLate, EXP_PAGE); else passCount++;
        checkCount++; if (lastBusy != EXP_BUSY) $display("[TB] FAIL restart_last_busy: got cycle %0d want %0d", lastBusy, EXP_BUSY); else passCount++;
        checkCount++; if (rdCyc != EXP_RDCYC || rdAdr !== EXP_RDADR) $display("[TB] FAIL restart_first_read: got %h at %0d want %h at %0d", rdAdr, rdCyc, EXP_RDADR, EXP_RDCYC); else passCount++;
        checkCount++; if (writes != EXP_WR) $display("[TB] FAIL restart_write_count: got %0d want %0d", writes, EXP_WR); else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] shadow [0:255];
        logic [43:0] outs;
        logic busyBefore = 1'b0;
        int postWrites = 0, postBusy = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        startMain(8'hC1);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) mainIf.reg_we = 1'b0;
            if (mainIf.oam_we) shadow[mainIf.oam_addr] = mainIf.oam_wdata;
            if (c == 100) busyBefore = mainIf.busy;
        end
        rst_n = 1'b0;
        #1;
        outs = {mainIf.reg_rdata, mainIf.src_addr, mainIf.src_rd_en, mainIf.oam_addr,
                mainIf.oam_wdata, mainIf.oam_we, mainIf.busy, mainIf.cpu_block};
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (mainIf.oam_we) postWrites++;
            if (mainIf.busy) postBusy++;
        end
        checkCount++; if (busyBefore !== 1'b1) $display("[TB] FAIL midreset_busy_before: got %b want 1", busyBefore); else passCount++;
        checkCount++; if (outs !== 44'h0) $display("[TB] FAIL midreset_outputs: got %h want 0", outs); else passCount++;
        checkCount++; if (postWrites != 0 || postBusy != 0) $display("[TB] FAIL midreset_quiet: got %0d writes %0d busy want 0 0", postWrites, postBusy); else passCount++;
        checkCount++; if (shadow[23] !== 8'h4D || shadow[24] !== 8'h00) $display("[TB] FAIL midreset_retained: got %h %h want 4d 00", shadow[23], shadow[24]); else passCount++;
        checkCount++; if (mainIf.reg_rdata !== 8'h00) $display("[TB] FAIL midreset_rdata: got %h want 00", mainIf.reg_rdata); else passCount++;
    endtask

    task automatic test_small_params();
        int writes = 0, badSpacing = 0, badData = 0, lastBusy = -1;
        @(negedge clk);
        smallIf.reg_we    = 1'b1;
        smallIf.reg_wdata = 8'h12;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) smallIf.reg_we = 1'b0;
            if (smallIf.busy) lastBusy = c;
            if (smallIf.oam_we) begin
                if (c != 2 + 2 * writes) badSpacing++;
                if (smallIf.oam_addr !== 8'(writes) || smallIf.oam_wdata !== (8'(writes) ^ 8'hA5)) badData++;
                writes++;
            end
        end
        checkCount++; if (writes != 4) $display("[TB] FAIL small_write_count: got %0d want 4", writes); else passCount++;
        checkCount++; if (badSpacing != 0) $display("[TB] FAIL small_spacing: got %0d misplaced want 0", badSpacing); else passCount++;
        checkCount++; if (badData != 0) $display("[TB] FAIL small_data: got %0d bad want 0", badData); else passCount++;
        checkCount++; if (lastBusy != 8) $display("[TB] FAIL small_last_busy: got cycle %0d want 8", lastBusy); else passCount++;
    endtask

    task automatic test_invariants();
        checkCount++; if (invViolations != 0) $display("[TB] FAIL invariants: got %0d violations want 0", invViolations); else passCount++;
    endtask

    initial begin
        rst_n             = 1'b0;
        mainIf.reg_we     = 1'b0;
        mainIf.reg_wdata  = 8'h00;
        smallIf.reg_we    = 1'b0;
        smallIf.reg_wdata = 8'h00;
        test_reset();
        test_transfer();
        test_echo();
        test_restart();
        test_reset_mid();
        test_small_params();
        test_invariants();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
